// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 BCM panel driver: scan FSM encoding,
// frame-buffer word layout and timing/width helpers.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CLKL,
    ST_CLKH,
    ST_BLANK,
    ST_LATCH,
    ST_SHOW
  } state_t;

  // Field index within rd_data = {R0,G0,B0,R1,G1,B1}; field f occupies bits [f*BPC +: BPC]
  localparam int F_R0 = 5;
  localparam int F_G0 = 4;
  localparam int F_B0 = 3;
  localparam int F_R1 = 2;
  localparam int F_G1 = 1;
  localparam int F_B1 = 0;

  // On-time of bit-plane p, doubling with each step in bit significance
  function automatic int on_time(input int base, input int p);
    return base << p;
  endfunction

  // Frame-buffer address width: {scan_row, col}
  function automatic int addr_w(input int rows, input int cols);
    return $clog2(rows / 2) + $clog2(cols);
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Loadable down-counter with a zero flag. A state lasting N cycles loads
// N-1 on entry and exits in the cycle where zero is high.
module hub75_bcm_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load takes priority; otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hub75_bcm_panel.sv
// HUB75 scan driver with binary-coded modulation: shifts one bit-plane of a
// scan row out of the frame buffer, latches it, then lights it for a time
// weighted by the plane's significance. Buffer swaps only at frame end.
module hub75_bcm_panel
  import hub75_pkg::*;
#(
  parameter  int COLS       = 64,
  parameter  int ROWS       = 32,
  parameter  int BPC        = 4,
  parameter  int CLK_DIV    = 3,
  parameter  int BASE_DELAY = 20,
  parameter  int RD_LAT     = 1,
  localparam int RW         = $clog2(ROWS / 2),
  localparam int AW         = addr_w(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            swap_req,
  output logic            swap_ack,
  output logic            buf_sel,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [6*BPC-1:0] rd_data,
  output logic            LP_CLK,
  output logic            LATCH,
  output logic            NOE,
  output logic [RW-1:0]   ROW,
  output logic [2:0]      RGB0,
  output logic [2:0]      RGB1,
  output logic            frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int PW = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int DW = 6 * BPC;
  localparam int TW = $clog2(on_time(BASE_DELAY, BPC - 1) + RD_LAT + CLK_DIV + 1);

  state_t          state, state_nx;
  logic [RW-1:0]   row_q, row_nx;
  logic [CW-1:0]   col_q, col_nx;
  logic [PW-1:0]   plane_q, plane_nx;
  logic            tmr_load, tmr_zero;
  logic [TW-1:0]   tmr_val;
  logic            last_col, last_plane, last_row, show_end, frame_end;
  logic [2:0]      rgb0_nx, rgb1_nx;

  // Bit p of colour field f in a frame-buffer word
  function automatic logic fbit(input logic [DW-1:0] d, input int f, input int p);
    logic [DW-1:0] s;
    s = d >> (f * BPC + p);
    return s[0];
  endfunction

  assign last_col   = (col_q == CW'(COLS - 1));
  assign last_plane = (plane_q == PW'(BPC - 1));
  assign last_row   = (row_q == RW'(ROWS / 2 - 1));
  assign show_end   = (state == ST_SHOW) && tmr_zero;
  assign frame_end  = show_end && last_plane && last_row;

  hub75_bcm_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .val  (tmr_val),
    .zero (tmr_zero)
  );

  // Scan FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next state and timer reload on entry to each timed state
  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE:  if (enable) state_nx = ST_REQ;
      ST_REQ: begin
        state_nx = ST_WAIT;
        tmr_load = 1'b1;
        tmr_val  = TW'(RD_LAT - 1);
      end
      ST_WAIT: if (tmr_zero) begin
        state_nx = ST_CLKL;
        tmr_load = 1'b1;
        tmr_val  = TW'(CLK_DIV - 1);
      end
      ST_CLKL: if (tmr_zero) begin
        state_nx = ST_CLKH;
        tmr_load = 1'b1;
        tmr_val  = TW'(CLK_DIV - 1);
      end
      ST_CLKH:  if (tmr_zero) state_nx = last_col ? ST_BLANK : ST_REQ;
      ST_BLANK: begin
        state_nx = ST_LATCH;
        tmr_load = 1'b1;
        tmr_val  = TW'(CLK_DIV - 1);
      end
      ST_LATCH: if (tmr_zero) begin
        state_nx = ST_SHOW;
        tmr_load = 1'b1;
        tmr_val  = TW'(on_time(BASE_DELAY, int'(plane_q)) - 1);
      end
      // A dropped enable is honoured only here, so a started plane always completes
      ST_SHOW:  if (tmr_zero) state_nx = enable ? ST_REQ : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Column/plane/row sequencing; plane advance happens before any IDLE so resume picks the next plane
  always_comb begin
    col_nx   = col_q;
    plane_nx = plane_q;
    row_nx   = row_q;
    if (state == ST_CLKH && tmr_zero) col_nx = last_col ? '0 : col_q + CW'(1);
    if (show_end) begin
      plane_nx = last_plane ? '0 : plane_q + PW'(1);
      if (last_plane) row_nx = last_row ? '0 : row_q + RW'(1);
    end
  end

  // Current-plane bits of the returned pixel pair
  always_comb begin
    rgb0_nx = {fbit(rd_data, F_R0, int'(plane_q)), fbit(rd_data, F_G0, int'(plane_q)),
               fbit(rd_data, F_B0, int'(plane_q))};
    rgb1_nx = {fbit(rd_data, F_R1, int'(plane_q)), fbit(rd_data, F_G1, int'(plane_q)),
               fbit(rd_data, F_B1, int'(plane_q))};
  end

  // Registered outputs decoded from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q      <= '0;
      col_q      <= '0;
      plane_q    <= '0;
      LP_CLK     <= 1'b0;
      LATCH      <= 1'b0;
      NOE        <= 1'b1;
      ROW        <= '0;
      RGB0       <= '0;
      RGB1       <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      buf_sel    <= 1'b0;
      swap_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      row_q      <= row_nx;
      col_q      <= col_nx;
      plane_q    <= plane_nx;
      LP_CLK     <= (state_nx == ST_CLKH);
      LATCH      <= (state_nx == ST_LATCH);
      NOE        <= (state_nx != ST_SHOW);
      rd_en      <= (state_nx == ST_REQ);
      if (state_nx == ST_REQ) rd_addr <= {row_nx, col_nx};
      if (state == ST_WAIT && tmr_zero) begin
        RGB0 <= rgb0_nx;
        RGB1 <= rgb1_nx;
      end
      if (state == ST_BLANK) ROW <= row_q;
      frame_done <= frame_end;
      // swap_req is a level: a request raised mid-frame simply waits here for the boundary
      swap_ack   <= frame_end && swap_req;
      if (frame_end && swap_req) buf_sel <= ~buf_sel;
    end
  end

endmodule

// File: tb/tb_hub75_bcm_panel.sv
// Directed bench for hub75_bcm_panel: instance A uses CLK_DIV=1/RD_LAT=1,
// instance B uses CLK_DIV=2/RD_LAT=3. Both have 4 cols, 4 rows, 2 planes.
module tb_hub75_bcm_panel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame-buffer word: R0=col, G0=~col, B0={row,row}, R1=01, G1=10, B1=col
  function automatic logic [11:0] mem(input logic [2:0] a);
    logic [1:0] c;
    c = a[1:0];
    return {c, ~c, {a[2], a[2]}, 2'b01, 2'b10, c};
  endfunction

  function automatic logic [2:0] exp_r0(input int c, input int p, input int r);
    logic [1:0] cv;
    logic [1:0] rv;
    cv = c[1:0];
    rv = r[1:0];
    return {cv[p], ~cv[p], rv[0]};
  endfunction

  function automatic logic [2:0] exp_r1(input int c, input int p);
    logic [1:0] cv;
    cv = c[1:0];
    return {p == 0, p == 1, cv[p]};
  endfunction

  // ---------------- instance A ----------------
  logic rst_a, en_a, swr_a, ack_a, bsel_a, rden_a, lp_a, lat_a, noe_a, fd_a;
  logic [2:0]  addr_a, rgb0_a, rgb1_a;
  logic [11:0] rdat_a;
  logic [0:0]  row_a;

  hub75_bcm_panel #(.COLS(4), .ROWS(4), .BPC(2), .CLK_DIV(1), .BASE_DELAY(2), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .swap_req(swr_a), .swap_ack(ack_a),
    .buf_sel(bsel_a), .rd_en(rden_a), .rd_addr(addr_a), .rd_data(rdat_a),
    .LP_CLK(lp_a), .LATCH(lat_a), .NOE(noe_a), .ROW(row_a),
    .RGB0(rgb0_a), .RGB1(rgb1_a), .frame_done(fd_a)
  );

  always @(posedge clk) rdat_a <= rden_a ? mem(addr_a) : 12'h000;

  logic lp_pa = 1'b0, noe_pa = 1'b1, lat_pa = 1'b0, bs_pa = 1'b0;
  int noe_run = 0, lat_run = 0;
  int rise_c[$], addr_q[$], noe_len[$], noe_fall[$], noe_rise[$], noe_row[$];
  int lat_len[$], lat_fall[$], fd_c[$], ack_c[$], tog_c[$];
  logic [2:0] rise_r0[$], rise_r1[$];

  always @(negedge clk) begin
    lp_pa  <= lp_a;
    noe_pa <= noe_a;
    lat_pa <= lat_a;
    bs_pa  <= bsel_a;
    if (lp_a && !lp_pa) begin
      rise_c.push_back(cyc);
      rise_r0.push_back(rgb0_a);
      rise_r1.push_back(rgb1_a);
    end
    if (rden_a) addr_q.push_back(int'(addr_a));
    if (!noe_a) noe_run <= noe_run + 1;
    if (!noe_a && noe_pa) begin
      noe_fall.push_back(cyc);
      noe_row.push_back(int'(row_a));
    end
    if (noe_a && !noe_pa) begin
      noe_len.push_back(noe_run);
      noe_rise.push_back(cyc);
      noe_run <= 0;
    end
    if (lat_a) lat_run <= lat_run + 1;
    if (!lat_a && lat_pa) begin
      lat_len.push_back(lat_run);
      lat_fall.push_back(cyc);
      lat_run <= 0;
    end
    if (fd_a) fd_c.push_back(cyc);
    if (ack_a) ack_c.push_back(cyc);
    if (bsel_a != bs_pa) tog_c.push_back(cyc);
  end

  // ---------------- instance B ----------------
  logic rst_b, en_b, swr_b, ack_b, bsel_b, rden_b, lp_b, lat_b, noe_b, fd_b;
  logic [2:0]  addr_b, rgb0_b, rgb1_b;
  logic [11:0] rdat_b, d1_b, d2_b;
  logic [0:0]  row_b;

  hub75_bcm_panel #(.COLS(4), .ROWS(4), .BPC(2), .CLK_DIV(2), .BASE_DELAY(2), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .swap_req(swr_b), .swap_ack(ack_b),
    .buf_sel(bsel_b), .rd_en(rden_b), .rd_addr(addr_b), .rd_data(rdat_b),
    .LP_CLK(lp_b), .LATCH(lat_b), .NOE(noe_b), .ROW(row_b),
    .RGB0(rgb0_b), .RGB1(rgb1_b), .frame_done(fd_b)
  );

  always @(posedge clk) begin
    d1_b   <= rden_b ? mem(addr_b) : 12'h000;
    d2_b   <= d1_b;
    rdat_b <= d2_b;
  end

  logic lp_pb = 1'b0, lat_pb = 1'b0;
  logic [2:0] r0_pb = 3'b000, r1_pb = 3'b000;
  int chg_b = 0, lat_cnt_b = 0;
  int rb_c[$], rb_gap[$];
  logic [2:0] rb_r0[$];

  always @(negedge clk) begin
    lp_pb  <= lp_b;
    lat_pb <= lat_b;
    r0_pb  <= rgb0_b;
    r1_pb  <= rgb1_b;
    if (rgb0_b != r0_pb || rgb1_b != r1_pb) chg_b <= cyc;
    if (lp_b && !lp_pb) begin
      rb_c.push_back(cyc);
      rb_r0.push_back(rgb0_b);
      rb_gap.push_back((rgb0_b != r0_pb || rgb1_b != r1_pb) ? 0 : cyc - chg_b);
    end
    if (lat_b && !lat_pb) lat_cnt_b <= lat_cnt_b + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b_r, b_a, b_n, lc;
    bit done;
    rst_a = 1'b0; en_a = 1'b0; swr_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0; swr_b = 1'b0;

    // 1: reset held with random inputs
    repeat (6) begin
      @(negedge clk);
      en_a  = 1'($urandom_range(0, 1));
      swr_a = 1'($urandom_range(0, 1));
      en_b  = 1'($urandom_range(0, 1));
      swr_b = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("rst_noe", noe_a, 1);
    chk("rst_latch", lat_a, 0);
    chk("rst_lpclk", lp_a, 0);
    chk("rst_row", row_a, 0);
    chk("rst_bufsel", bsel_a, 0);
    chk("rst_rden", rden_a, 0);
    chk("rst_fdone", fd_a, 0);
    chk("rst_rgb0", rgb0_a, 0);
    chk("rst_noe_b", noe_b, 1);

    // 2-4: one full frame with a swap request raised early
    en_a = 1'b1; swr_a = 1'b0; en_b = 1'b0; swr_b = 1'b0;
    rst_a = 1'b1;
    b_r = cyc;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (cyc - b_r == 5) swr_a = 1'b1;
      if (ack_a) swr_a = 1'b0;
      if (fd_a) done = 1'b1;
    end
    #1;
    chk("frame_timeout", done, 1);
    chk("rise_cnt", rise_c.size(), 16);
    for (int i = 1; i < 4; i++) chk("lp_period", rise_c[i] - rise_c[i-1], 4);
    for (int i = 0; i < 16; i++) begin
      chk("rise_rgb0", rise_r0[i], exp_r0(i % 4, (i / 4) % 2, i / 8));
      chk("rise_rgb1", rise_r1[i], exp_r1(i % 4, (i / 4) % 2));
      chk("rd_addr", addr_q[i], (i / 8) * 4 + (i % 4));
    end
    chk("noe_cnt", noe_len.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("noe_len", noe_len[i], (i % 2 == 0) ? 2 : 4);
      chk("show_row", noe_row[i], i / 2);
      chk("latch_len", lat_len[i], 1);
      chk("latch_before_show", lat_fall[i], noe_fall[i]);
    end
    chk("fdone_cnt", fd_c.size(), 1);
    chk("fdone_at_show_end", fd_c[0], noe_rise[3]);
    chk("ack_cnt", ack_c.size(), 1);
    chk("ack_with_fdone", ack_c[0], fd_c[0]);
    chk("toggle_cnt", tog_c.size(), 1);
    chk("toggle_with_fdone", tog_c[0], fd_c[0]);
    chk("bufsel_after", bsel_a, 1);

    // 5: drop enable mid-shift of frame 2 row 0 plane 0, then resume
    b_a = 16;
    b_r = rise_c.size();
    b_n = noe_len.size();
    repeat (5) @(negedge clk);
    en_a = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    chk("stop_rises", rise_c.size(), b_r + 4);
    chk("stop_reads", addr_q.size(), b_a + 4);
    chk("stop_shows", noe_len.size(), b_n + 1);
    chk("stop_show_len", noe_len[b_n], 2);
    chk("idle_noe", noe_a, 1);
    chk("idle_rden", rden_a, 0);
    en_a = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    chk("resume_addr", addr_q[b_a + 4], 0);
    chk("resume_rgb0", rise_r0[b_r + 4], exp_r0(0, 1, 0));
    chk("resume_rgb1", rise_r1[b_r + 4], exp_r1(0, 1));
    chk("resume_show_len", noe_len[b_n + 1], 4);
    chk("resume_row", noe_row[b_n + 1], 0);

    // 6: longer read latency and slower shift clock, then reset mid-SHOW
    en_b = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 100 && rb_c.size() < 4; i++) @(negedge clk);
    #1;
    chk("b_rise_cnt", rb_c.size() >= 4, 1);
    for (int i = 1; i < 4; i++) chk("b_lp_period", rb_c[i] - rb_c[i-1], 8);
    for (int i = 0; i < 4; i++) begin
      chk("b_setup", rb_gap[i] >= 2, 1);
      chk("b_rgb0", rb_r0[i], exp_r0(i, 0, 0));
    end
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!noe_b) done = 1'b1;
    end
    chk("b_show_seen", done, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("b_rst_noe", noe_b, 1);
    chk("b_rst_latch", lat_b, 0);
    chk("b_rst_lpclk", lp_b, 0);
    chk("b_rst_rgb0", rgb0_b, 0);
    chk("b_rst_rden", rden_b, 0);
    lc = lat_cnt_b;
    repeat (4) @(negedge clk);
    #1;
    chk("b_no_latch", lat_cnt_b, lc);
    chk("b_hold_noe", noe_b, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
